// File: rtl/sprite_motion_ctrl.sv
// Sprite position controller: synced buttons -> frame-paced, bounds-checked (x,y) with move pulse.
// Latency: buttons +2 cycles sync; frame_tick at cycle N -> position/moveSprite at N+2; no backpressure.
module sprite_motion_ctrl #(
    parameter int INIT_X   = 50,
    parameter int INIT_Y   = 300,
    parameter int STEP     = 1,
    parameter int RATE_DIV = 1,
    parameter int MIN_X    = 0,
    parameter int MAX_X    = 800,
    parameter int MIN_Y    = 0,
    parameter int MAX_Y    = 600,
    parameter int SPRITE_W = 25,
    parameter int SPRITE_H = 25,
    parameter int WRAP     = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        left,
    input  logic        right,
    input  logic        up,
    input  logic        down,
    input  logic        frame_tick,
    input  logic        move_en,
    input  logic        load,
    input  logic [10:0] load_x,
    input  logic [9:0]  load_y,
    output logic [10:0] position_x,
    output logic [9:0]  position_y,
    output logic        moveSprite,
    output logic [2:0]  dir_state,
    output logic [3:0]  at_edge
);
    localparam logic signed [11:0] X_LO   = 12'(MIN_X);
    localparam logic signed [11:0] X_HI   = 12'(MAX_X - SPRITE_W);
    localparam logic signed [11:0] Y_LO   = 12'(MIN_Y);
    localparam logic signed [11:0] Y_HI   = 12'(MAX_Y - SPRITE_H);
    localparam logic signed [11:0] STEP_S = 12'(STEP);
    localparam logic [7:0]         CNT_TOP = 8'(RATE_DIV - 1);

    typedef enum logic [1:0] {S_IDLE, S_HOLD, S_COMMIT} state_t;

    state_t             state, state_nxt;
    logic [7:0]         cnt, cnt_nxt;
    logic [3:0]         btn_s1, btn_s2;
    logic               go_left, go_right, go_up, go_down;
    logic               active, do_commit;
    logic signed [11:0] cur_x, cur_y, nx, ny, lx, ly;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            btn_s1 <= '0;
            btn_s2 <= '0;
        end else begin
            btn_s1 <= {left, right, up, down};
            btn_s2 <= btn_s1;
        end
    end

    // Opposing buttons on one axis cancel; the axes resolve independently.
    assign go_left  = btn_s2[3] & ~btn_s2[2];
    assign go_right = btn_s2[2] & ~btn_s2[3];
    assign go_up    = btn_s2[1] & ~btn_s2[0];
    assign go_down  = btn_s2[0] & ~btn_s2[1];
    assign active   = (go_left | go_right | go_up | go_down) & move_en;

    assign cur_x = $signed({1'b0, position_x});
    assign cur_y = $signed({2'b00, position_y});

    always_comb begin
        dir_state = 3'b000;
        if ((go_left | go_right) && (go_up | go_down)) dir_state = 3'b101;
        else if (go_left)                              dir_state = 3'b001;
        else if (go_right)                             dir_state = 3'b010;
        else if (go_down)                              dir_state = 3'b011;
        else if (go_up)                                dir_state = 3'b100;
    end

    // Signed 12-bit so an underflow past the left/top limit is visible before truncation.
    always_comb begin
        nx = cur_x;
        ny = cur_y;
        if (go_left) begin
            nx = cur_x - STEP_S;
            if (nx < X_LO) nx = (WRAP != 0) ? X_HI : X_LO;
        end else if (go_right) begin
            nx = cur_x + STEP_S;
            if (nx > X_HI) nx = (WRAP != 0) ? X_LO : X_HI;
        end
        if (go_up) begin
            ny = cur_y - STEP_S;
            if (ny < Y_LO) ny = (WRAP != 0) ? Y_HI : Y_LO;
        end else if (go_down) begin
            ny = cur_y + STEP_S;
            if (ny > Y_HI) ny = (WRAP != 0) ? Y_LO : Y_HI;
        end
    end

    always_comb begin
        lx = $signed({1'b0, load_x});
        ly = $signed({2'b00, load_y});
        if (lx < X_LO)      lx = X_LO;
        else if (lx > X_HI) lx = X_HI;
        if (ly < Y_LO)      ly = Y_LO;
        else if (ly > Y_HI) ly = Y_HI;
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        do_commit = 1'b0;
        case (state)
            S_IDLE: begin
                cnt_nxt = CNT_TOP;
                if (active) state_nxt = S_HOLD;
            end
            S_HOLD: begin
                if (!active) begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = CNT_TOP;
                end else if (frame_tick) begin
                    if (cnt == CNT_TOP) begin
                        state_nxt = S_COMMIT;
                        cnt_nxt   = 8'd0;
                    end else begin
                        cnt_nxt = cnt + 8'd1;
                    end
                end
            end
            S_COMMIT: begin
                if (active) begin
                    do_commit = 1'b1;
                    state_nxt = S_HOLD;
                end else begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = CNT_TOP;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = CNT_TOP;
            end
        endcase
        // A load discards any movement committing in the same cycle.
        if (load) begin
            state_nxt = S_IDLE;
            cnt_nxt   = CNT_TOP;
            do_commit = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            cnt        <= CNT_TOP;
            position_x <= 11'(INIT_X);
            position_y <= 10'(INIT_Y);
            moveSprite <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (load) begin
                position_x <= lx[10:0];
                position_y <= ly[9:0];
                moveSprite <= 1'b1;
            end else if (do_commit) begin
                position_x <= nx[10:0];
                position_y <= ny[9:0];
                moveSprite <= (nx != cur_x) || (ny != cur_y);
            end else begin
                moveSprite <= 1'b0;
            end
        end
    end

    assign at_edge = {cur_y >= Y_HI, cur_y <= Y_LO, cur_x >= X_HI, cur_x <= X_LO};
endmodule
